// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_pkg
//  Purpose  : Shared CPU constants and types used by the fetch stage.
//             - NOP_INST           : canonical bubble instruction (add x0,x0,x0)
//             - DEFAULT_RESET_ADDR : default PC after reset
//             - fetch_state_e      : fetch FSM states (RUN, PEND)
//  Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  localparam logic [31:0] NOP_INST           = 32'h0000_0033;
  localparam logic [31:0] DEFAULT_RESET_ADDR = 32'h0000_0000;

  // PEND means a redirect arrived while the I-cache was missing; the target
  // waits in pend_pc until the outstanding fetch returns.
  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_PEND = 1'b1
  } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/fetch_npc.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_npc
//  Purpose  : Next-PC redirect selection for the fetch stage. Computes the
//             jal / jalr targets and picks the highest-priority redirect.
//  Ports    :
//    br_taken_i   in  1   EX branch resolved taken
//    br_target_i  in  32  EX branch target
//    jal_i        in  1   decode holds a valid jal
//    jalr_i       in  1   decode holds a valid jalr
//    hold_i       in  1   decode load-use stall (suppresses jal/jalr)
//    immediate_i  in  32  decode immediate
//    jalr_rs1_i   in  32  forwarded rs1 for jalr
//    if_pc_i      in  32  PC of the instruction currently in decode
//    redirect_o   out 1   some redirect is requested this cycle
//    target_o     out 32  selected redirect target
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_npc (
  input  logic        br_taken_i,
  input  logic [31:0] br_target_i,
  input  logic        jal_i,
  input  logic        jalr_i,
  input  logic        hold_i,
  input  logic [31:0] immediate_i,
  input  logic [31:0] jalr_rs1_i,
  input  logic [31:0] if_pc_i,
  output logic        redirect_o,
  output logic [31:0] target_o
);

  logic        jal_go;
  logic        jalr_go;
  logic [31:0] jal_tgt;
  logic [31:0] jalr_sum;
  logic [31:0] jalr_tgt;

  // A held decode stage may be looking at stale operands, so its jumps wait.
  assign jal_go   = jal_i  & ~hold_i;
  assign jalr_go  = jalr_i & ~hold_i;

  // All adds wrap modulo 2^32; jalr clears bit 0 of the sum.
  assign jal_tgt  = if_pc_i + immediate_i;
  assign jalr_sum = jalr_rs1_i + immediate_i;
  assign jalr_tgt = {jalr_sum[31:1], 1'b0};

  assign redirect_o = br_taken_i | jal_go | jalr_go;

  // The older instruction (EX branch) wins over the younger one in decode.
  always_comb begin
    target_o = jalr_tgt;
    if (br_taken_i) begin
      target_o = br_target_i;
    end else if (jal_go) begin
      target_o = jal_tgt;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch.sv
`default_nettype none
// ============================================================================
//  Module   : fetch
//  Purpose  : Instruction-fetch stage plus IF/ID pipeline register. Holds the
//             PC, drives the I-memory read address, selects the next PC
//             (sequential / jal / jalr / taken branch / deferred redirect)
//             and generates the decode flush.
//  Ports    :
//    i_clk, i_rst              clock, synchronous active-high reset
//    o_imem_raddr, o_imem_ren  I-memory address (= pc) and read enable
//    i_imem_rdata              fetched word, valid when i_inst_busy=0
//    i_inst_busy, i_data_busy  I-cache / D-cache miss
//    i_hold                    decode load-use stall
//    i_jal, i_jalr             decode jump requests
//    i_immediate, i_jalr_rs1   jump operands from decode
//    i_br_taken, i_br_target   EX branch resolution
//    o_flush                   kill the instruction in decode
//    o_inst, o_pc, o_nxt_pc, o_vld   IF/ID register contents
//  Revision : 1.0 - initial release
// ============================================================================
module fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = DEFAULT_RESET_ADDR
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic [31:0] o_imem_raddr,
  output logic        o_imem_ren,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_inst_busy,
  input  logic        i_data_busy,
  input  logic        i_hold,
  input  logic        i_jal,
  input  logic        i_jalr,
  input  logic [31:0] i_immediate,
  input  logic [31:0] i_jalr_rs1,
  input  logic        i_br_taken,
  input  logic [31:0] i_br_target,
  output logic        o_flush,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc,
  output logic [31:0] o_nxt_pc,
  output logic        o_vld
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  pend_pc_q;
  logic [31:0]  inst_q;
  logic [31:0]  ifid_pc_q;
  logic [31:0]  ifid_nxt_q;
  logic         vld_q;

  logic         redirect;
  logic [31:0]  target;
  logic [31:0]  pc_inc;

  fetch_npc u_npc (
    .br_taken_i  (i_br_taken),
    .br_target_i (i_br_target),
    .jal_i       (i_jal),
    .jalr_i      (i_jalr),
    .hold_i      (i_hold),
    .immediate_i (i_immediate),
    .jalr_rs1_i  (i_jalr_rs1),
    .if_pc_i     (ifid_pc_q),
    .redirect_o  (redirect),
    .target_o    (target)
  );

  assign pc_inc       = pc_q + 32'd4;
  assign o_imem_raddr = pc_q;
  assign o_imem_ren   = ~i_rst;

  // During a D-cache freeze EX re-presents the branch afterwards, so the
  // flush must not fire early.
  assign o_flush      = i_br_taken & ~i_data_busy;

  assign o_inst   = inst_q;
  assign o_pc     = ifid_pc_q;
  assign o_nxt_pc = ifid_nxt_q;
  assign o_vld    = vld_q;

  // Bubbles only touch inst/vld; pc and nxt_pc keep their last values so the
  // jal base in decode stays stable.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_ADDR;
      pend_pc_q  <= 32'h0000_0000;
      inst_q     <= NOP_INST;
      ifid_pc_q  <= RESET_ADDR;
      ifid_nxt_q <= RESET_ADDR + 32'd4;
      vld_q      <= 1'b0;
    end else if (!i_data_busy) begin
      if (i_inst_busy) begin
        // Address stays put until the miss returns.
        if (state_q == ST_RUN) begin
          if (redirect) begin
            pend_pc_q <= target;
            state_q   <= ST_PEND;
            inst_q    <= NOP_INST;
            vld_q     <= 1'b0;
          end else if (!i_hold) begin
            inst_q    <= NOP_INST;
            vld_q     <= 1'b0;
          end
        end else begin
          // Decode can only hold bubbles here, so only EX can redirect.
          inst_q <= NOP_INST;
          vld_q  <= 1'b0;
          if (i_br_taken) begin
            pend_pc_q <= i_br_target;
          end
        end
      end else if (state_q == ST_PEND) begin
        // Returned word belongs to the squashed path; drop it.
        pc_q    <= i_br_taken ? i_br_target : pend_pc_q;
        inst_q  <= NOP_INST;
        vld_q   <= 1'b0;
        state_q <= ST_RUN;
      end else if (redirect) begin
        pc_q   <= target;
        inst_q <= NOP_INST;
        vld_q  <= 1'b0;
      end else if (!i_hold) begin
        inst_q     <= i_imem_rdata;
        ifid_pc_q  <= pc_q;
        ifid_nxt_q <= pc_inc;
        vld_q      <= 1'b1;
        pc_q       <= pc_inc;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/fetch.md
# fetch

Instruction-fetch stage and IF/ID pipeline register feeding the `dec` stage. It holds the PC and drives the instruction-memory/I-cache read address. It selects the next PC from four sources: sequential, decode-stage jal/jalr, EX-stage taken branch, or a redirect deferred across an I-cache miss. It delivers `{inst, pc, nxt_pc, vld}` to decode and generates the decode flush.

## Interface
Parameters:
- RESET_ADDR, 32'h0000_0000, PC value loaded on reset.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- o_imem_raddr  out  32  fetch address (= pc_q, combinational)
- o_imem_ren  out  1  read enable; 0 during reset, else 1
- i_imem_rdata  in  32  fetched word, valid same cycle when i_inst_busy=0
- i_inst_busy  in  1  I-cache miss; rdata invalid
- i_data_busy  in  1  D-cache miss; freezes the stage
- i_hold  in  1  decode load-use stall (decode o_hold)
- i_jal  in  1  decode holds valid jal
- i_jalr  in  1  decode holds valid jalr
- i_immediate  in  32  decode immediate
- i_jalr_rs1  in  32  forwarded rs1 for jalr
- i_br_taken  in  1  EX branch resolved taken
- i_br_target  in  32  EX branch target
- o_flush  out  1  kill the instruction currently in decode
- o_inst  out  32  IF/ID instruction
- o_pc  out  32  IF/ID PC
- o_nxt_pc  out  32  IF/ID PC+4 (link value)
- o_vld  out  1  IF/ID valid

## Operation
- Redirect target priority:
  - i_br_taken → i_br_target.
  - else i_jal & !i_hold → o_pc + i_immediate.
  - else i_jalr & !i_hold → (i_jalr_rs1 + i_immediate) & ~32'h1.
- All adds are 32-bit, wrapping modulo 2^32. jal/jalr are ignored while i_hold.
- o_flush = i_br_taken & !i_data_busy (combinational).
- Bubble: inst=32'h0000_0033, vld=0, pc and nxt_pc unchanged.
- FSM states RUN and PEND, with pend_pc register. Per-edge rules, highest priority first:
  1. i_data_busy: pc, IF/ID, FSM and pend_pc all hold. Redirect inputs are ignored; EX re-presents them after the freeze.
  2. i_inst_busy, RUN: o_imem_raddr is held.
     - A redirect sets pend_pc ← target and moves to PEND; IF/ID gets a bubble.
     - Otherwise IF/ID holds if i_hold, else gets a bubble.
  3. i_inst_busy, PEND: IF/ID gets a bubble.
     - i_br_taken overwrites pend_pc.
     - jal/jalr are ignored (decode can only hold bubbles).
  4. !i_inst_busy, PEND: the returned word is discarded.
     - pc ← (i_br_taken ? i_br_target : pend_pc).
     - IF/ID gets a bubble; FSM → RUN.
  5. !i_inst_busy, RUN with a redirect: pc ← target; IF/ID gets a bubble.
  6. !i_inst_busy, RUN, i_hold and no redirect: pc and IF/ID hold.
  7. Otherwise: IF/ID ← {i_imem_rdata, pc_q, pc_q+4, 1}; pc ← pc_q+4.
- i_br_taken overrides i_hold.

## Timing
- Reset values: pc_q=RESET_ADDR, o_inst=32'h0000_0033, o_pc=RESET_ADDR, o_nxt_pc=RESET_ADDR+4, o_vld=0, FSM=RUN, pend_pc=0, o_imem_ren=0 during reset. o_flush follows its inputs.
- Reset mid-miss or mid-PEND: the next edge restores all reset values and the pending redirect is dropped.
- Fetch-to-decode latency: 1 cycle on a hit.
- Taken-branch penalty: 2 bubbles (decode flushed, IF/ID bubble).
- jal/jalr penalty: 1 bubble.
- The first fetch after reset deassertion is RESET_ADDR, with o_vld=1 one edge later on a hit.
- o_imem_raddr never changes while i_inst_busy=1.

## Structure
- Shared package `cpu_pkg`: NOP constant 32'h0000_0033, default RESET_ADDR, FSM state enum {RUN, PEND}.
- Sub-module `fetch_npc`: combinational target adders and priority mux, outputs redirect flag and target.
- The top level holds the pc register, pend register/FSM and the IF/ID register.

## Test plan
- Reset, then hits from 0x0: o_pc sequence 0x0, 0x4, 0x8 with o_vld=1 from the second edge after reset release; o_nxt_pc=o_pc+4.
- Decode jal at o_pc=0x10, i_immediate=0x40 → next o_vld=0 bubble, then o_pc=0x50; o_flush stays 0.
- i_br_taken with target 0x200 while i_hold=1 → o_flush=1 the same cycle, IF/ID bubble, fetch 0x200 next.
- Miss at 0x20 (i_inst_busy 3 cycles) plus jalr at cycle 1 with rs1=0x101, imm=0 → o_imem_raddr stays 0x20; after busy drops the word is discarded and pc=0x100.
- PEND holding 0x100, then i_br_taken to 0x300 during the miss → fetch resumes at 0x300.
- i_data_busy=1 for 4 cycles while i_br_taken=1 → no state change and o_flush=0; redirect to the target on the first free cycle.
